servo_lock_sequencer: RTL and testbench
=======================================

# servo_lock_sequencer

Sequences lock/unlock movements of the servo so that only one command runs at a time. It shares the servo between two requesters: the HPS, over an Avalon-MM slave, and a local request port for keypad or pushbutton logic. It enforces a mechanical settle time after every movement and can re-lock automatically after a timeout. It sits between the bus fabric and `servo_controller`, and drives that module's `locked` input.

## Interface
Parameters:
- `SETTLE_CYCLES`, 25_000_000: cycles the servo is given to finish a movement (0.5 s at 50 MHz); must be ≥ 1.
- `RELOCK_CYCLES`, 500_000_000: cycles spent in the unlocked state before automatic re-lock (10 s); must be ≥ 1.
- `CNT_W`, 32: width of the shared cycle counter; must hold max(SETTLE_CYCLES, RELOCK_CYCLES).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  8  Avalon write data; any nonzero value = lock command, zero = unlock command.
- `read`  in  1  Avalon read strobe.
- `readdata`  out  8  status word: bit0 `locked`, bit1 `busy`, bit2 `pend_valid`, bit3 `relock_fired`; bits 7:4 are 0.
- `local_valid`  in  1  local requester has a command.
- `local_lock`  in  1  local command: 1 = lock, 0 = unlock.
- `local_ready`  out  1  local command accepted this cycle when `local_valid && local_ready`.
- `locked`  out  1  drive to `servo_controller.locked`.
- `busy`  out  1  high while a movement is settling.

## Operation
- States: `S_LOCKED`, `S_UNLOCKING`, `S_UNLOCKED`, `S_LOCKING`.
- Avalon writes are always accepted. They go into a one-entry pending register (`pend_valid`, `pend_lock`).
  - A second write before the first is consumed overwrites it: last write wins.
- `local_ready` = stable state (`S_LOCKED` or `S_UNLOCKED`) && !`pend_valid` && !`write`.
- Arbitration in a stable state, in priority order:
  1. pending Avalon command, which clears `pend_valid`;
  2. local handshake;
  3. auto-relock.
- A write arriving in the same cycle as the pending register is consumed is captured. It acts on the next stable-state cycle.
- Command equal to the current stable state: consumed with no movement. In `S_UNLOCKED`, an unlock command restarts the relock counter.
- Command opposite to the current state:
  - go to `S_LOCKING` or `S_UNLOCKING`;
  - `locked` switches on the transition edge;
  - the counter loads 0;
  - after SETTLE_CYCLES cycles, enter the matching stable state.
- Commands arriving during settle only affect the pending register. They are never dropped; last write wins.
- `S_UNLOCKED`: the counter increments every cycle. Reaching RELOCK_CYCLES−1 with no higher-priority command triggers the internal lock command and sets `relock_fired`.
- `relock_fired` is sticky and clears on any Avalon write.

## Timing
- Reset values:
  - state `S_LOCKED`, `locked`=1, `busy`=0;
  - `pend_valid`=0, `relock_fired`=0, counter 0;
  - `readdata`=0, `local_ready`=0 during the reset cycle.
- Reset mid-settle aborts immediately to `S_LOCKED` and discards the pending command.
- Write in cycle N while stable and idle:
  - `pend_valid`=1 in N+1;
  - state transition and `locked` change in N+2.
- Local handshake in cycle N: state and `locked` change in N+1.
- `busy` is high for exactly SETTLE_CYCLES cycles per movement.
- `readdata` is registered and valid the cycle after `read`. It reflects status sampled in the `read` cycle.
- Counter comparisons use unsigned `CNT_W`-bit arithmetic. The counter never wraps: it saturates at its terminal value.

## Configuration
- `SERVO_AUTO_RELOCK_EN`:
  - Defined: auto-relock timer active as described.
  - Undefined: `S_UNLOCKED` holds indefinitely; `relock_fired` is tied to 0; the counter is used for settling only; RELOCK_CYCLES is ignored.

## Structure
- Package `servo_seq_pkg`:
  - state enum `servo_state_t`;
  - status bit index constants (`ST_LOCKED_BIT`, etc.);
  - command encoding constants `CMD_UNLOCK`/`CMD_LOCK`.
- Sub-module `servo_seq_timer`:
  - loadable up-counter with `clear`, `enable`, terminal-count compare input and `done` output;
  - shared between settle and relock, since the two never overlap.

## Test plan
- Reset, then write 0x00 at cycle 10 → `locked` falls at cycle 12, `busy` high for SETTLE_CYCLES, state `S_UNLOCKED`; read → 0x00.
- During a settle: write 0x01 then 0x00 → single pending unlock executes after settle; no lock movement occurs.
- Same-cycle Avalon write 0x00 and `local_valid` with lock=1 in `S_LOCKED` → `local_ready`=0; Avalon unlock executes first; local lock accepted after settle.
- With `SERVO_AUTO_RELOCK_EN` and RELOCK_CYCLES=100: unlock, wait → lock begins exactly 100 cycles after `S_UNLOCKED` entry; read bit3=1; next write clears it. Without the macro: stays unlocked for 1000 cycles.
- Assert reset mid-`S_UNLOCKING` with a pending write → next cycle `S_LOCKED`, `locked`=1, `pend_valid`=0.
- Redundant lock command in `S_LOCKED` → consumed, `busy` stays 0, `locked` unchanged.

Source files
------------

// File: rtl/servo_seq_pkg.sv
// Shared types and constants for the servo lock sequencer.
package servo_seq_pkg;

  typedef enum logic [1:0] {
    S_LOCKED    = 2'd0,
    S_UNLOCKING = 2'd1,
    S_UNLOCKED  = 2'd2,
    S_LOCKING   = 2'd3
  } servo_state_t;

  localparam int ST_LOCKED_BIT = 0;
  localparam int ST_BUSY_BIT   = 1;
  localparam int ST_PEND_BIT   = 2;
  localparam int ST_RELOCK_BIT = 3;

  localparam logic CMD_UNLOCK = 1'b0;
  localparam logic CMD_LOCK   = 1'b1;

  function automatic logic is_stable(input servo_state_t s);
    return (s == S_LOCKED) || (s == S_UNLOCKED);
  endfunction

endpackage

// File: rtl/servo_seq_timer.sv
// Saturating up-counter shared by the settle and relock timeouts.
module servo_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable && (count < term))
      count <= count + 1'b1;
  end

  // >= rather than == keeps done asserted if the terminal value shrinks under us
  assign done = (count >= term);

endmodule

// File: rtl/servo_lock_sequencer.sv
// Serialises lock/unlock moves from the Avalon slave and a local port onto one servo.
// Optional auto-relock timer is built when SERVO_AUTO_RELOCK_EN is defined.
module servo_lock_sequencer
  import servo_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 25_000_000,
  parameter int RELOCK_CYCLES = 500_000_000,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] writedata,
  input  logic       read,
  output logic [7:0] readdata,
  input  logic       local_valid,
  input  logic       local_lock,
  output logic       local_ready,
  output logic       locked,
  output logic       busy
);

  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOCK_TERM = CNT_W'(RELOCK_CYCLES - 1);

  servo_state_t     state;
  logic             pend_valid;
  logic             pend_lock;
  logic             relock_fired;

  logic             stable;
  logic             local_take;
  logic             relock_take;
  logic             cmd_take;
  logic             cmd_lock;
  logic             move;
  logic             settle_end;
  logic             tmr_clear;
  logic             tmr_enable;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_term;
  logic [7:0]       status;

  always_comb begin
    stable      = is_stable(state);
    local_ready = !reset && stable && !pend_valid && !write;
    local_take  = local_valid && local_ready;
`ifdef SERVO_AUTO_RELOCK_EN
    relock_take = (state == S_UNLOCKED) && !pend_valid && !local_take && tmr_done;
    tmr_enable  = 1'b1;
`else
    relock_take = 1'b0;
    tmr_enable  = !stable;
`endif
    cmd_take   = stable && (pend_valid || local_take || relock_take);
    cmd_lock   = pend_valid ? pend_lock : (local_take ? local_lock : CMD_LOCK);
    move       = cmd_take && (cmd_lock != (state == S_LOCKED));
    settle_end = !stable && tmr_done;
    // Any consumed command restarts the count, which covers the redundant-unlock relock restart
    tmr_clear  = cmd_take || settle_end;
    tmr_term   = stable ? RELOCK_TERM : SETTLE_TERM;

    status                = '0;
    status[ST_LOCKED_BIT] = locked;
    status[ST_BUSY_BIT]   = busy;
    status[ST_PEND_BIT]   = pend_valid;
    status[ST_RELOCK_BIT] = relock_fired;
  end

  servo_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .term   (tmr_term),
    .done   (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOCKED;
      locked       <= 1'b1;
      busy         <= 1'b0;
      pend_valid   <= 1'b0;
      pend_lock    <= CMD_UNLOCK;
      relock_fired <= 1'b0;
      readdata     <= '0;
    end else begin
      case (state)
        S_LOCKED, S_UNLOCKED: begin
          if (move) begin
            state  <= cmd_lock ? S_LOCKING : S_UNLOCKING;
            locked <= cmd_lock;
            busy   <= 1'b1;
          end
        end
        S_UNLOCKING: begin
          if (tmr_done) begin
            state <= S_UNLOCKED;
            busy  <= 1'b0;
          end
        end
        S_LOCKING: begin
          if (tmr_done) begin
            state <= S_LOCKED;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= S_LOCKED;
          locked <= 1'b1;
          busy   <= 1'b0;
        end
      endcase

      // A write landing on the consume cycle is kept: capture beats clear
      if (write) begin
        pend_valid <= 1'b1;
        pend_lock  <= |writedata;
      end else if (cmd_take && pend_valid) begin
        pend_valid <= 1'b0;
      end

`ifdef SERVO_AUTO_RELOCK_EN
      if (relock_take)
        relock_fired <= 1'b1;
      else if (write)
        relock_fired <= 1'b0;
`else
      relock_fired <= 1'b0;
`endif

      if (read)
        readdata <= status;
    end
  end

endmodule

// File: tb/tb_servo_lock_sequencer.sv
// Directed bench for servo_lock_sequencer with short settle/relock times.
module tb_servo_lock_sequencer;

  localparam int SETTLE = 8;
  localparam int RELOCK = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] writedata;
  logic       read;
  logic [7:0] readdata;
  logic       local_valid;
  logic       local_lock;
  logic       local_ready;
  logic       locked;
  logic       busy;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  servo_lock_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .RELOCK_CYCLES (RELOCK),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .local_valid (local_valid),
    .local_lock  (local_lock),
    .local_ready (local_ready),
    .locked      (locked),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_settle(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    read = 1'b1;
    step();
    read = 1'b0;
    chk(tag, {24'b0, readdata}, {24'b0, exp});
  endtask

  initial begin
    int n;
    reset = 1'b1; write = 1'b0; writedata = '0; read = 1'b0;
    local_valid = 1'b0; local_lock = 1'b0;

    // reset state
    step();
    chk("rst_locked", locked, 1);
    chk("rst_busy", busy, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_local_ready", local_ready, 0);
    step();
    reset = 1'b0;
    #1;
    chk("idle_local_ready", local_ready, 1);
    repeat (3) step();

    // unlock via Avalon: pend at N+1, movement at N+2
    write = 1'b1; writedata = 8'h00;
    #1;
    chk("ready_blocked_by_write", local_ready, 0);
    step();
    write = 1'b0;
    chk("unl_n1_locked", locked, 1);
    chk("unl_n1_busy", busy, 0);
    step();
    chk("unl_n2_locked", locked, 0);
    chk("unl_n2_busy", busy, 1);
    wait_settle(n);
    chk("unl_settle_len", n, SETTLE);
    chk("unl_done_locked", locked, 0);
    do_read("unl_read", 8'h00);

    // lock movement, then lock+unlock writes mid-settle collapse to one unlock
    write = 1'b1; writedata = 8'h01;
    step();
    write = 1'b0;
    step();
    chk("lk_start_locked", locked, 1);
    step();
    write = 1'b1; writedata = 8'h01;
    step();
    writedata = 8'h00;
    step();
    write = 1'b0;
    do_read("lk_pend_read", 8'h07);
    wait_settle(n);
    chk("lk_end_locked", locked, 1);
    chk("lk_end_busy", busy, 0);
    step();
    chk("pend_unl_locked", locked, 0);
    chk("pend_unl_busy", busy, 1);
    wait_settle(n);
    chk("pend_unl_settle_len", n, SETTLE);
    repeat (5) step();
    chk("no_extra_move_locked", locked, 0);
    chk("no_extra_move_busy", busy, 0);

    // local handshake lock: movement at N+1
    local_valid = 1'b1; local_lock = 1'b1;
    #1;
    chk("loc_ready", local_ready, 1);
    step();
    local_valid = 1'b0;
    chk("loc_n1_locked", locked, 1);
    chk("loc_n1_busy", busy, 1);
    wait_settle(n);
    chk("loc_settle_len", n, SETTLE);

    // same-cycle Avalon unlock and local lock: Avalon wins, local waits
    write = 1'b1; writedata = 8'h00;
    local_valid = 1'b1; local_lock = 1'b1;
    #1;
    chk("arb_ready_n0", local_ready, 0);
    step();
    write = 1'b0;
    #1;
    chk("arb_ready_n1", local_ready, 0);
    step();
    chk("arb_unl_locked", locked, 0);
    chk("arb_unl_ready", local_ready, 0);
    wait_settle(n);
    chk("arb_unl_settle_len", n, SETTLE);
    chk("arb_post_ready", local_ready, 1);
    step();
    local_valid = 1'b0;
    chk("arb_loc_locked", locked, 1);
    chk("arb_loc_busy", busy, 1);
    wait_settle(n);

    // redundant lock in S_LOCKED
    write = 1'b1; writedata = 8'h5A;
    step();
    write = 1'b0;
    step();
    chk("red_busy_a", busy, 0);
    step();
    chk("red_busy_b", busy, 0);
    chk("red_locked", locked, 1);
    do_read("red_read", 8'h01);

    // reset mid-unlock with a pending write
    write = 1'b1; writedata = 8'h00;
    step();
    write = 1'b0;
    step();
    chk("mid_unlocking", locked, 0);
    write = 1'b1; writedata = 8'h01;
    step();
    write = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", local_ready, 0);
    step();
    reset = 1'b0;
    chk("mid_rst_locked", locked, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_readdata", readdata, 0);
    do_read("mid_rst_read", 8'h01);
    repeat (3) step();
    chk("mid_rst_no_move", busy, 0);

    // unlock, then observe relock behaviour
    write = 1'b1; writedata = 8'h00;
    step();
    write = 1'b0;
    step();
    wait_settle(n);
    chk("rl_unlocked", locked, 0);
`ifdef SERVO_AUTO_RELOCK_EN
    n = 0;
    while (!locked && n < 300) begin
      n++;
      step();
    end
    chk("rl_delay", n, RELOCK);
    chk("rl_busy", busy, 1);
    do_read("rl_read_fired", 8'h0B);
    write = 1'b1; writedata = 8'h01;
    step();
    write = 1'b0;
    do_read("rl_read_cleared", 8'h07);
    wait_settle(n);
`else
    repeat (1000) step();
    chk("hold_locked", locked, 0);
    chk("hold_busy", busy, 0);
    do_read("hold_read", 8'h00);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
